// File: rtl/sram_test_seq.sv
// Write/read pattern self-test sequencer driving an SRAM controller over a start/busy handshake.
// Define SRAM_TEST_INV_PASS_EN to add a second write/read pass using the inverted pattern.
module sram_test_seq #(
    parameter logic [18:0] LAST_ADDR = 19'h7FFFF,
    parameter logic [7:0]  SEED      = 8'hA5,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic        sram_start,
    output logic        sram_rw,
    output logic [18:0] sram_addr,
    output logic [7:0]  sram_wdata,
    input  logic [7:0]  sram_rdata,
    input  logic        sram_data_ready,
    input  logic        sram_busy,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout_err,
    output logic [15:0] err_count,
    output logic [18:0] first_err_addr
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_ISSUE = 3'd1,
        WR_WAIT  = 3'd2,
        RD_ISSUE = 3'd3,
        RD_WAIT  = 3'd4,
        CHECK    = 3'd5,
        DONE     = 3'd6
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [18:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        rw_q, rw_d;
    logic        start_q, start_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic        tmo_q, tmo_d;
    logic [15:0] err_q, err_d;
    logic [18:0] ferr_q, ferr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        seen_q, seen_d;
    logic        got_q, got_d;
    logic [7:0]  rdata_q, rdata_d;
`ifdef SRAM_TEST_INV_PASS_EN
    logic        inv_q, inv_d;
`endif

    logic        in_wait_s, op_done_s, op_tmo_s, last_s, accept_s, mismatch_s;
    logic [7:0]  rd_exp_s;

    function automatic logic [7:0] pattern(input logic [7:0] a);
        return a ^ SEED;
    endfunction

    // Handshake status: an operation completes once busy has been seen high and then drops.
    always_comb begin
        in_wait_s = (state_q == WR_WAIT) || (state_q == RD_WAIT);
        op_done_s = seen_q && !sram_busy;
        op_tmo_s  = !op_done_s && (cnt_q == TMO_LAST);
        last_s    = (addr_q == LAST_ADDR);
        accept_s  = start && ((state_q == IDLE) || (state_q == DONE));
`ifdef SRAM_TEST_INV_PASS_EN
        rd_exp_s  = inv_q ? ~pattern(addr_q[7:0]) : pattern(addr_q[7:0]);
`else
        rd_exp_s  = pattern(addr_q[7:0]);
`endif
        mismatch_s = !got_q || (rdata_q != rd_exp_s);
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: state_d = start ? WR_ISSUE : state_q;
            WR_ISSUE:   state_d = WR_WAIT;
            WR_WAIT: begin
                if (op_done_s)     state_d = last_s ? RD_ISSUE : WR_ISSUE;
                else if (op_tmo_s) state_d = DONE;
                else               state_d = WR_WAIT;
            end
            RD_ISSUE:   state_d = RD_WAIT;
            RD_WAIT: begin
                if (op_done_s)     state_d = CHECK;
                else if (op_tmo_s) state_d = DONE;
                else               state_d = RD_WAIT;
            end
            CHECK: begin
`ifdef SRAM_TEST_INV_PASS_EN
                if (!last_s)     state_d = RD_ISSUE;
                else if (!inv_q) state_d = WR_ISSUE;
                else             state_d = DONE;
`else
                state_d = last_s ? DONE : RD_ISSUE;
`endif
            end
            default:    state_d = IDLE;
        endcase
    end

    // Datapath, result counters and registered output values.
    always_comb begin
        addr_d = addr_q;
        err_d  = err_q;
        ferr_d = ferr_q;
        tmo_d  = tmo_q;
`ifdef SRAM_TEST_INV_PASS_EN
        inv_d  = inv_q;
`endif
        if (accept_s) begin
            addr_d = 19'd0;
            err_d  = 16'd0;
            ferr_d = 19'd0;
            tmo_d  = 1'b0;
`ifdef SRAM_TEST_INV_PASS_EN
            inv_d  = 1'b0;
`endif
        end else begin
            case (state_q)
                WR_WAIT: begin
                    if (op_done_s)     addr_d = last_s ? 19'd0 : addr_q + 19'd1;
                    else if (op_tmo_s) tmo_d = 1'b1;
                    else               addr_d = addr_q;
                end
                RD_WAIT: begin
                    if (op_tmo_s) tmo_d = 1'b1;
                    else          tmo_d = tmo_q;
                end
                CHECK: begin
                    if (mismatch_s) begin
                        err_d  = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
                        ferr_d = (err_q == 16'd0) ? addr_q : ferr_q;
                    end else begin
                        err_d  = err_q;
                    end
                    if (!last_s) begin
                        addr_d = addr_q + 19'd1;
                    end else begin
`ifdef SRAM_TEST_INV_PASS_EN
                        addr_d = 19'd0;
                        inv_d  = 1'b1;
`else
                        addr_d = addr_q;
`endif
                    end
                end
                default: addr_d = addr_q;
            endcase
        end

        cnt_d   = ((state_q == WR_ISSUE) || (state_q == RD_ISSUE)) ? 8'd0
                : (in_wait_s ? cnt_q + 8'd1 : cnt_q);
        seen_d  = ((state_q == WR_ISSUE) || (state_q == RD_ISSUE)) ? 1'b0
                : ((in_wait_s && sram_busy) ? 1'b1 : seen_q);
        got_d   = got_q;
        rdata_d = rdata_q;
        if (state_q == RD_ISSUE) begin
            got_d = 1'b0;
        end else if ((state_q == RD_WAIT) && sram_data_ready) begin
            got_d   = 1'b1;
            rdata_d = sram_rdata;
        end else begin
            got_d = got_q;
        end

        start_d = (state_d == WR_ISSUE) || (state_d == RD_ISSUE);
        rw_d    = (state_d == WR_ISSUE) ? 1'b0 : ((state_d == RD_ISSUE) ? 1'b1 : rw_q);
`ifdef SRAM_TEST_INV_PASS_EN
        wdata_d = (state_d != WR_ISSUE) ? wdata_q
                : (inv_d ? ~pattern(addr_d[7:0]) : pattern(addr_d[7:0]));
`else
        wdata_d = (state_d == WR_ISSUE) ? pattern(addr_d[7:0]) : wdata_q;
`endif
        busy_d  = (state_d != IDLE) && (state_d != DONE);
        done_d  = (state_d == DONE);
        pass_d  = (state_d == DONE) && (err_d == 16'd0) && !tmo_d;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= 19'd0;
            wdata_q <= 8'd0;
            rw_q    <= 1'b1;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            tmo_q   <= 1'b0;
            err_q   <= 16'd0;
            ferr_q  <= 19'd0;
            cnt_q   <= 8'd0;
            seen_q  <= 1'b0;
            got_q   <= 1'b0;
            rdata_q <= 8'd0;
`ifdef SRAM_TEST_INV_PASS_EN
            inv_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rw_q    <= rw_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            ferr_q  <= ferr_d;
            cnt_q   <= cnt_d;
            seen_q  <= seen_d;
            got_q   <= got_d;
            rdata_q <= rdata_d;
`ifdef SRAM_TEST_INV_PASS_EN
            inv_q   <= inv_d;
`endif
        end
    end

    assign sram_start     = start_q;
    assign sram_rw        = rw_q;
    assign sram_addr      = addr_q;
    assign sram_wdata     = wdata_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign timeout_err    = tmo_q;
    assign err_count      = err_q;
    assign first_err_addr = ferr_q;
endmodule

// File: doc/sram_test_seq.md
SRAM_TEST_SEQ -- requirements
Module: sram_test_seq

Interface
REQ-001 SHALL have parameter LAST_ADDR, default 19'h7FFFF, last address tested (range 0..LAST_ADDR, ascending).
REQ-002 SHALL have parameter SEED, default 8'hA5, pattern data = addr[7:0] ^ SEED.
REQ-003 SHALL have parameter TIMEOUT, default 16, max cycles waited per operation before abort (range 2..255).
REQ-004 SHALL have clk  in  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have reset_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have start  in  1  single-cycle pulse that begins a test run.
REQ-007 SHALL have sram_start  out  1  start_operation pulse to SRAM controller.
REQ-008 SHALL have sram_rw  out  1  1=read, 0=write.
REQ-009 SHALL have sram_addr  out  19  address to controller.
REQ-010 SHALL have sram_wdata  out  8  write data to controller.
REQ-011 SHALL have sram_rdata  in  8  registered read data from controller.
REQ-012 SHALL have sram_data_ready  in  1  read data valid this cycle.
REQ-013 SHALL have sram_busy  in  1  controller busy.
REQ-014 SHALL have busy  out  1  test run in progress.
REQ-015 SHALL have done  out  1  run finished; held until next accepted start.
REQ-016 SHALL have pass  out  1  valid while done: err_count==0 and no timeout.
REQ-017 SHALL have timeout_err  out  1  an operation exceeded TIMEOUT.
REQ-018 SHALL have err_count  out  16  mismatches in run, saturating at 16'hFFFF.
REQ-019 SHALL have first_err_addr  out  19  address of first mismatch; 0 if none.

Function
REQ-020 SHALL implement states IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT, CHECK, DONE.
REQ-021 IDLE/DONE + start: clear err_count, first_err_addr, timeout_err, done, pass; addr=0; -> WR_ISSUE next cycle; busy=1 from that cycle.
REQ-022 WR_ISSUE: sram_start=1, sram_rw=0, sram_addr=addr, sram_wdata=pattern for exactly one cycle; -> WR_WAIT.
REQ-023 WR_WAIT: completion = sram_busy seen high, then sram_busy low; if addr==LAST_ADDR -> RD_ISSUE with addr=0, else addr+1 -> WR_ISSUE.
REQ-024 RD_ISSUE: sram_start=1, sram_rw=1 for one cycle; -> RD_WAIT.
REQ-025 RD_WAIT: in the cycle sram_data_ready=1, capture sram_rdata; -> CHECK once sram_busy returns low.
REQ-026 CHECK (1 cycle): mismatch increments err_count (saturating); first_err_addr loaded only on first mismatch; then last address -> DONE, else addr+1 -> RD_ISSUE.
REQ-027 sram_addr, sram_wdata and sram_rw SHALL hold stable from ISSUE until leaving the matching WAIT/CHECK state.
REQ-028 sram_start SHALL be 0 in all states except WR_ISSUE/RD_ISSUE.
REQ-029 Per-op cycle counter resets on ISSUE; reaching TIMEOUT in WR_WAIT/RD_WAIT sets timeout_err=1 -> DONE.
REQ-030 DONE: busy=0, done=1, pass = (err_count==0 && !timeout_err).
REQ-031 start while busy=1 SHALL be ignored.
REQ-032 Address wrap: addr never exceeds LAST_ADDR; LAST_ADDR=0 tests one location.

Reset
REQ-033 reset_n low SHALL immediately force IDLE, sram_start=0, sram_rw=1, sram_addr=0, sram_wdata=0, busy=0, done=0, pass=0, timeout_err=0, err_count=0, first_err_addr=0.
REQ-034 Reset mid-run SHALL abandon the run without further sram_start pulses; the next start begins a fresh run.

Configuration
REQ-035 Macro SRAM_TEST_INV_PASS_EN defined: after read pass, a second write pass and read pass with pattern ~(addr[7:0]^SEED) run before DONE; errors accumulate into same counters.
REQ-036 Macro undefined: one write pass and one read pass only; no inverted-pattern logic present.

Verification
REQ-037 LAST_ADDR=3, SEED=8'hA5, ideal SRAM model, start pulse -> writes A5,A4,A7,A6 to 0..3, then four reads; done=1, pass=1, err_count=0.
REQ-038 Model with bit0 stuck-at-0 at address 2 (writes A7, reads A6) -> err_count=1, first_err_addr=2, pass=0.
REQ-039 Model never asserts sram_busy, TIMEOUT=16 -> timeout_err=1, done=1, pass=0 within 18 cycles of start.
REQ-040 reset_n low during read pass at addr 1 -> all outputs at reset values same cycle; new start -> complete clean run, pass=1.
REQ-041 start re-pulsed while busy -> ignored; run count and err_count unaffected.
REQ-042 SRAM_TEST_INV_PASS_EN defined, LAST_ADDR=1 -> writes A5,A4 then 5A,5B; 8 total operations; pass=1.
